// File: rtl/freq_counter_ctrl_mc.sv
// rtl/freq_counter_ctrl_mc.sv - multi-channel frequency-counter control register slave
// Optional overrun tracking enabled by defining FREQ_CTRL_OVERRUN_EN.
module freq_counter_ctrl_mc #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NCHAN      = 4,
   parameter logic [DATA_WIDTH-1:0] MAGIC      = 'h0B
) (
   input  logic                        clock,
   input  logic                        nreset,
   input  logic [ADDR_WIDTH-1:0]       address,
   input  logic                        read,
   output logic [DATA_WIDTH-1:0]       readdata,
   output logic                        readdatavalid,
   input  logic                        write,
   input  logic [DATA_WIDTH-1:0]       writedata,
   output logic                        irq,
   output logic [DATA_WIDTH-1:0]       cycle_count,
   output logic [DATA_WIDTH-1:0]       input_select,
   output logic [NCHAN-1:0]            enable,
   output logic [NCHAN-1:0]            busy,
   input  logic [NCHAN-1:0]            done,
   input  logic [NCHAN*DATA_WIDTH-1:0] edge_count
);
   localparam logic [ADDR_WIDTH-1:0] A_INPUT_SEL  = ADDR_WIDTH'(8'h00);
   localparam logic [ADDR_WIDTH-1:0] A_CYCLECOUNT = ADDR_WIDTH'(8'h01);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL       = ADDR_WIDTH'(8'h02);
   localparam logic [ADDR_WIDTH-1:0] A_START      = ADDR_WIDTH'(8'h03);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_STATUS = ADDR_WIDTH'(8'h04);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_MASK   = ADDR_WIDTH'(8'h05);
   localparam logic [ADDR_WIDTH-1:0] A_MAGIC      = ADDR_WIDTH'(8'h06);
   localparam logic [ADDR_WIDTH-1:0] A_BUSY       = ADDR_WIDTH'(8'h07);
   localparam logic [ADDR_WIDTH-1:0] A_RESULT     = ADDR_WIDTH'(8'h10);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                r_state [NCHAN];
   logic [DATA_WIDTH-1:0] r_result [NCHAN];
   logic [DATA_WIDTH-1:0] r_input_sel;
   logic [DATA_WIDTH-1:0] r_cycle_count;
   logic                  r_cont;
   logic [NCHAN-1:0]      r_irq_status;
   logic [NCHAN-1:0]      r_irq_mask;
   logic [NCHAN-1:0]      r_enable;
   logic [NCHAN-1:0]      r_done_q;
   logic [DATA_WIDTH-1:0] r_readdata;
   logic                  r_readdatavalid;

   logic [NCHAN-1:0]      w_done_rise;
   logic [NCHAN-1:0]      w_capture;
   logic [NCHAN-1:0]      w_start;
   logic [NCHAN-1:0]      w_w1c;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_irq_ovr;

`ifdef FREQ_CTRL_OVERRUN_EN
   localparam logic [ADDR_WIDTH-1:0] A_OVERRUN     = ADDR_WIDTH'(8'h08);
   localparam logic [ADDR_WIDTH-1:0] A_OVERRUN_CNT = ADDR_WIDTH'(8'h09);

   logic [NCHAN-1:0]      r_overrun;
   logic [DATA_WIDTH-1:0] r_ovr_cnt;
   logic [NCHAN-1:0]      w_ovr_event;
   logic [NCHAN-1:0]      w_ovr_w1c;
   logic [4:0]            w_ovr_inc;
   logic [DATA_WIDTH:0]   w_ovr_sum;

   always_comb begin
      w_ovr_event = w_capture & r_irq_status;
      w_ovr_w1c   = (write && address == A_OVERRUN) ? writedata[NCHAN-1:0] : '0;
      w_ovr_inc   = '0;
      for (int c = 0; c < NCHAN; c++) w_ovr_inc = w_ovr_inc + 5'(w_ovr_event[c]);
      w_ovr_sum   = {1'b0, r_ovr_cnt} + (DATA_WIDTH+1)'(w_ovr_inc);
      w_irq_ovr   = |(r_overrun & r_irq_mask);
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_overrun <= '0;
         r_ovr_cnt <= '0;
      end else begin
         r_overrun <= (r_overrun & ~w_ovr_w1c) | w_ovr_event;
         if (write && address == A_OVERRUN_CNT)
            r_ovr_cnt <= '0;
         else if (w_ovr_sum[DATA_WIDTH])
            r_ovr_cnt <= '1;
         else
            r_ovr_cnt <= w_ovr_sum[DATA_WIDTH-1:0];
      end
   end
`else
   assign w_irq_ovr = 1'b0;
`endif

   always_comb begin
      w_done_rise = done & ~r_done_q;
      w_start     = (write && address == A_START) ? writedata[NCHAN-1:0] : '0;
      w_w1c       = (write && address == A_IRQ_STATUS) ? writedata[NCHAN-1:0] : '0;
      for (int c = 0; c < NCHAN; c++) begin
         w_capture[c] = (r_state[c] == S_RUN) && w_done_rise[c];
         busy[c]      = (r_state[c] == S_RUN);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         A_INPUT_SEL:   w_rdata = r_input_sel;
         A_CYCLECOUNT:  w_rdata = r_cycle_count;
         A_CTRL:        w_rdata[0] = r_cont;
         A_IRQ_STATUS:  w_rdata[NCHAN-1:0] = r_irq_status;
         A_IRQ_MASK:    w_rdata[NCHAN-1:0] = r_irq_mask;
         A_MAGIC:       w_rdata = MAGIC;
         A_BUSY:        w_rdata[NCHAN-1:0] = busy;
`ifdef FREQ_CTRL_OVERRUN_EN
         A_OVERRUN:     w_rdata[NCHAN-1:0] = r_overrun;
         A_OVERRUN_CNT: w_rdata = r_ovr_cnt;
`endif
         default:       w_rdata = '0;
      endcase
      for (int c = 0; c < NCHAN; c++)
         if (address == A_RESULT + ADDR_WIDTH'(c)) w_rdata = r_result[c];
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int c = 0; c < NCHAN; c++) begin
            r_state[c]  <= S_IDLE;
            r_result[c] <= '0;
         end
         r_input_sel     <= '0;
         r_cycle_count   <= '0;
         r_cont          <= 1'b0;
         r_irq_status    <= '0;
         r_irq_mask      <= '0;
         r_enable        <= '0;
         r_done_q        <= '0;
         r_readdata      <= '0;
         r_readdatavalid <= 1'b0;
      end else begin
         r_done_q        <= done;
         r_readdatavalid <= read;
         r_readdata      <= read ? w_rdata : '0;
         if (write && address == A_INPUT_SEL)  r_input_sel   <= writedata;
         if (write && address == A_CYCLECOUNT) r_cycle_count <= writedata;
         if (write && address == A_CTRL)       r_cont        <= writedata[0];
         if (write && address == A_IRQ_MASK)   r_irq_mask    <= writedata[NCHAN-1:0];
         // a capture in the same cycle as its W1C keeps the status bit set
         r_irq_status <= (r_irq_status & ~w_w1c) | w_capture;
         for (int c = 0; c < NCHAN; c++) begin
            r_enable[c] <= 1'b0;
            case (r_state[c])
               S_IDLE: if (w_start[c]) begin
                  r_state[c]  <= S_RUN;
                  r_enable[c] <= 1'b1;
               end
               S_RUN: if (w_capture[c]) begin
                  r_result[c] <= edge_count[c*DATA_WIDTH +: DATA_WIDTH];
                  if (r_cont) r_enable[c] <= 1'b1;
                  else        r_state[c]  <= S_IDLE;
               end
               default: r_state[c] <= S_IDLE;
            endcase
         end
      end
   end

   assign readdata      = r_readdata;
   assign readdatavalid = r_readdatavalid;
   assign cycle_count   = r_cycle_count;
   assign input_select  = r_input_sel;
   assign enable        = r_enable;
   assign irq           = (|(r_irq_status & r_irq_mask)) | w_irq_ovr;
endmodule

// File: tb/tb_freq_counter_ctrl_mc.sv
// tb/tb_freq_counter_ctrl_mc.sv - randomized self-checking bench for freq_counter_ctrl_mc
module tb_freq_counter_ctrl_mc;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int N  = 4;

   logic          clock = 1'b0;
   logic          nreset = 1'b0;
   logic [AW-1:0] address = '0;
   logic          read = 1'b0;
   logic [DW-1:0] readdata;
   logic          readdatavalid;
   logic          write = 1'b0;
   logic [DW-1:0] writedata = '0;
   logic          irq;
   logic [DW-1:0] cycle_count;
   logic [DW-1:0] input_select;
   logic [N-1:0]  enable;
   logic [N-1:0]  busy;
   logic [N-1:0]  done = '0;
   logic [N*DW-1:0] edge_count = '0;

   int checks = 0;
   int errors = 0;

   // reference model: what software would expect to see
   logic [DW-1:0] m_result [N];
   logic [N-1:0]  m_status, m_mask, m_busy;
   logic          m_cont;

   freq_counter_ctrl_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NCHAN(N), .MAGIC('h0B)) dut (
      .clock(clock), .nreset(nreset), .address(address), .read(read),
      .readdata(readdata), .readdatavalid(readdatavalid), .write(write),
      .writedata(writedata), .irq(irq), .cycle_count(cycle_count),
      .input_select(input_select), .enable(enable), .busy(busy),
      .done(done), .edge_count(edge_count)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      for (int c = 0; c < N; c++) m_result[c] = '0;
      m_status = '0; m_mask = '0; m_busy = '0; m_cont = 1'b0;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock); address = a; writedata = d; write = 1'b1;
      @(negedge clock); write = 1'b0;
      if (a == 8'h03) m_busy = m_busy | d[N-1:0];
      if (a == 8'h04) m_status = m_status & ~d[N-1:0];
      if (a == 8'h05) m_mask = d[N-1:0];
      if (a == 8'h02) m_cont = d[0];
   endtask

   task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      @(negedge clock); address = a; read = 1'b1;
      @(negedge clock); read = 1'b0; d = readdata;
   endtask

   task automatic raise_done(input logic [N-1:0] sub);
      logic [DW-1:0] v;
      for (int c = 0; c < N; c++) if (sub[c]) begin
         v = $urandom;
         edge_count[c*DW +: DW] = v;
         if (m_busy[c]) begin
            m_result[c] = v; m_status[c] = 1'b1;
            if (!m_cont) m_busy[c] = 1'b0;
         end
      end
      done = done | sub;
      @(negedge clock);
   endtask

   task automatic drop_done();
      done = '0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [DW-1:0] d, exp;
      logic [AW-1:0] addrs [14];
      addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h10, 8'h13, 8'h0A, 8'h20};
      nreset = 1'b0;
      repeat (3) @(negedge clock);
      nreset = 1'b1;
      model_reset();
      checks++;
      if (enable !== '0 || busy !== '0 || irq !== 1'b0 || readdatavalid !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: en=%h busy=%h irq=%b rdv=%b, want all 0", enable, busy, irq, readdatavalid);
      end
      foreach (addrs[i]) begin
         exp = (addrs[i] == 8'h06) ? 32'h0B : 32'h0;
         bus_read(addrs[i], d);
         checks++;
         if (readdatavalid !== 1'b1 || d !== exp) begin
            errors++; $display("FAIL reset_read[%h]: data=%h rdv=%b, want data=%h rdv=1", addrs[i], d, readdatavalid, exp);
         end
         @(negedge clock);
         checks++;
         if (readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rdv_pulse[%h]: rdv=%b one cycle later, want 0", addrs[i], readdatavalid);
         end
      end
   endtask

   task automatic test_single();
      logic [DW-1:0] d, sel;
      sel = $urandom;
      bus_write(8'h00, sel);
      bus_write(8'h01, 32'd1000);
      bus_write(8'h05, 32'h1);
      checks++;
      if (cycle_count !== 32'd1000 || input_select !== sel) begin
         errors++; $display("FAIL cfg_outputs: cc=%0d sel=%h, want 1000 %h", cycle_count, input_select, sel);
      end
      bus_write(8'h03, 32'h1);
      checks++;
      if (enable !== 4'b0001 || busy !== 4'b0001) begin
         errors++; $display("FAIL start_ch0: en=%b busy=%b, want 0001 0001", enable, busy);
      end
      @(negedge clock);
      checks++;
      if (enable !== 4'b0000) begin
         errors++; $display("FAIL enable_pulse: en=%b, want 0000", enable);
      end
      edge_count[0 +: DW] = 32'd12345;
      done[0] = 1'b1;
      m_result[0] = 32'd12345; m_status[0] = 1'b1; m_busy[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (irq !== 1'b1 || busy !== 4'b0000) begin
         errors++; $display("FAIL capture_ch0: irq=%b busy=%b, want 1 0000", irq, busy);
      end
      drop_done();
      bus_read(8'h10, d);
      checks++;
      if (d !== 32'd12345) begin errors++; $display("FAIL result0: got %0d want 12345", d); end
      bus_read(8'h04, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL status_ch0: got %h want 1", d); end
      bus_write(8'h04, 32'h1);
      checks++;
      if (irq !== 1'b0 || busy[0] !== 1'b0) begin
         errors++; $display("FAIL w1c_ch0: irq=%b busy0=%b, want 0 0", irq, busy[0]);
      end
   endtask

   task automatic test_multi();
      logic [DW-1:0] d;
      logic [N-1:0] order [3];
      order = '{4'b0100, 4'b1001, 4'b0010};
      bus_write(8'h05, 32'h0);
      bus_write(8'h03, 32'hF);
      checks++;
      if (enable !== 4'hF || busy !== 4'hF) begin
         errors++; $display("FAIL start_all: en=%h busy=%h, want F F", enable, busy);
      end
      foreach (order[i]) begin
         raise_done(order[i]);
         checks++;
         if (irq !== 1'b0 || busy !== m_busy) begin
            errors++; $display("FAIL multi_step%0d: irq=%b busy=%b, want 0 %b", i, irq, busy, m_busy);
         end
         drop_done();
      end
      for (int c = 0; c < N; c++) begin
         bus_read(8'(16 + c), d);
         checks++;
         if (d !== m_result[c]) begin errors++; $display("FAIL multi_result%0d: got %h want %h", c, d, m_result[c]); end
      end
      bus_read(8'h04, d);
      checks++;
      if (d !== 32'hF) begin errors++; $display("FAIL multi_status: got %h want F", d); end
      bus_write(8'h04, 32'hF);
   endtask

   task automatic test_continuous();
      logic [DW-1:0] d;
      bus_write(8'h02, 32'h1);
      bus_write(8'h03, 32'h2);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         raise_done(4'b0010);
         checks++;
         if (enable !== 4'b0010 || busy !== 4'b0010) begin
            errors++; $display("FAIL cont_rearm%0d: en=%b busy=%b, want 0010 0010", k, enable, busy);
         end
         drop_done();
         checks++;
         if (enable !== 4'b0000) begin errors++; $display("FAIL cont_pulse%0d: en=%b want 0000", k, enable); end
      end
      bus_write(8'h02, 32'h0);
      raise_done(4'b0010);
      checks++;
      if (enable !== 4'b0000 || busy !== 4'b0000) begin
         errors++; $display("FAIL cont_stop: en=%b busy=%b, want 0000 0000", enable, busy);
      end
      drop_done();
      raise_done(4'b0010);
      drop_done();
      bus_read(8'h11, d);
      checks++;
      if (d !== m_result[1]) begin errors++; $display("FAIL cont_last_result: got %h want %h", d, m_result[1]); end
      bus_write(8'h04, 32'hF);
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] d;
      bus_write(8'h03, 32'h4);
      checks++;
      if (enable !== 4'b0100) begin errors++; $display("FAIL start_ch2: en=%b want 0100", enable); end
      bus_write(8'h03, 32'h4);
      checks++;
      if (enable !== 4'b0000 || busy !== 4'b0100) begin
         errors++; $display("FAIL start_busy: en=%b busy=%b, want 0000 0100", enable, busy);
      end
      address = 8'h04; writedata = 32'h4; write = 1'b1;
      m_status[2] = 1'b0;
      raise_done(4'b0100);
      write = 1'b0;
      drop_done();
      bus_read(8'h04, d);
      checks++;
      if (d[2] !== 1'b1 || d !== 32'(m_status)) begin
         errors++; $display("FAIL capture_wins: status=%h want %h", d, m_status);
      end
      bus_read(8'h12, d);
      checks++;
      if (d !== m_result[2]) begin errors++; $display("FAIL simul_result2: got %h want %h", d, m_result[2]); end
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      int guard;
      for (int it = 0; it < 8; it++) begin
         bus_write(8'h05, 32'($urandom_range(0, 15)));
         bus_write(8'h03, 32'($urandom_range(1, 15)));
         guard = 0;
         while (m_busy != '0 && guard < 40) begin
            raise_done(4'($urandom));
            checks++;
            if (busy !== m_busy || irq !== |(m_status & m_mask)) begin
               errors++; $display("FAIL rand%0d_step: busy=%b irq=%b, want %b %b", it, busy, irq, m_busy, |(m_status & m_mask));
            end
            drop_done();
            guard++;
         end
         checks++;
         if (busy !== '0) begin errors++; $display("FAIL rand%0d_drain: busy=%b want 0000", it, busy); end
         for (int c = 0; c < N; c++) begin
            bus_read(8'(16 + c), d);
            checks++;
            if (d !== m_result[c]) begin errors++; $display("FAIL rand%0d_result%0d: got %h want %h", it, c, d, m_result[c]); end
         end
         bus_read(8'h04, d);
         checks++;
         if (d !== 32'(m_status)) begin errors++; $display("FAIL rand%0d_status: got %h want %h", it, d, m_status); end
         bus_write(8'h04, 32'($urandom_range(0, 15)));
         checks++;
         if (irq !== |(m_status & m_mask)) begin
            errors++; $display("FAIL rand%0d_irq: got %b want %b", it, irq, |(m_status & m_mask));
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [DW-1:0] d, exp_ovr, exp_cnt;
      bus_write(8'h03, 32'h1);
      nreset = 1'b0;
      edge_count[0 +: DW] = $urandom;
      done[0] = 1'b1;
      repeat (2) @(negedge clock);
      nreset = 1'b1;
      model_reset();
      @(negedge clock);
      checks++;
      if (busy !== '0 || enable !== '0 || irq !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs: busy=%b en=%b irq=%b, want 0", busy, enable, irq);
      end
      bus_read(8'h10, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_result0: got %h want 0", d); end
      bus_read(8'h04, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_status: got %h want 0", d); end
      drop_done();
      for (int k = 0; k < 2; k++) begin
         bus_write(8'h03, 32'h1);
         raise_done(4'b0001);
         drop_done();
      end
`ifdef FREQ_CTRL_OVERRUN_EN
      exp_ovr = 32'h1; exp_cnt = 32'h1;
`else
      exp_ovr = 32'h0; exp_cnt = 32'h0;
`endif
      bus_read(8'h08, d);
      checks++;
      if (d !== exp_ovr) begin errors++; $display("FAIL overrun: got %h want %h", d, exp_ovr); end
      bus_read(8'h09, d);
      checks++;
      if (d !== exp_cnt) begin errors++; $display("FAIL overrun_cnt: got %h want %h", d, exp_cnt); end
      bus_read(8'h10, d);
      checks++;
      if (d !== m_result[0]) begin errors++; $display("FAIL post_reset_result0: got %h want %h", d, m_result[0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_continuous();
      test_simultaneous();
      test_random();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
